float_split_pipe: RTL and testbench
===================================

Name: float_split_pipe

Overview:
- Pipelined, parametrised IEEE-754 splitter: takes one packed float per valid/ready handshake and returns sign, integer magnitude and truncated fractional magnitude as separate fixed-point fields.
- Sits between the float input stage and the decimal digit generator in the FLOAT_TO_DECIMAL path.
- Supersedes the single-precision combinational integer/fraction splitter: arbitrary exponent and mantissa widths, denormal/zero/Inf/NaN classification, saturation, inexact flag and backpressure.

Parameters:
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa width (hidden bit excluded).
- INT_W, 24, integer output width.
- FRAC_W, 23, fraction output width (binary weights 2^-1 down to 2^-FRAC_W).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  1+EXP_W+MAN_W  {sign, exponent, mantissa}.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  sign bit of the input.
- out_int  out  INT_W  floor(|x|), or saturated.
- out_frac  out  FRAC_W  truncated fractional part of |x|.
- out_flags  out  5  {nan, inf, ovf, zero, inexact}.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation): both stage valids and all output registers go to 0. out_valid=0. in_ready=1 in the first cycle after reset release. In-flight words are discarded.
- Pipeline: two register stages, S1 (decode) and S2 (shift/pack; drives the outputs). Latency is 2 cycles from an accepted input to out_valid when unstalled. Throughput is 1 word per cycle.
- Handshake:
  - Transfer occurs when valid&ready.
  - S2 loads when !s2_valid | out_ready.
  - S1 loads when !s1_valid | S2 loads.
  - in_ready = !s1_valid | S2 loads (combinational from out_ready; no skid buffer).
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - Results are never dropped or duplicated, and order is preserved.
- S1 decode:
  - E = exponent field; M = mantissa field.
  - E==0: hidden bit = 0, effective exponent e = 1-bias (zero or denormal).
  - Otherwise: hidden bit = 1, e = E-bias, signed with EXP_W+1 bits.
  - Class: NaN (E all ones, M!=0), Inf (E all ones, M==0), Zero (E==0, M==0), else finite.
- S2 arithmetic for finite values: significand S = {hidden, M}, and |x| = S*2^(e-MAN_W).
  - ovf = (e >= INT_W).
  - Otherwise form S << (FRAC_W + e) into a wide vector with MAN_W+1+INT_W+FRAC_W bits. A negative shift is a right shift; bits shifted out below position 0 set inexact.
  - out_int = bits above the binary point.
  - out_frac = the top FRAC_W fraction bits.
  - inexact = OR of all discarded lower fraction bits.
- Special outputs:
  - ovf: out_int = all ones, out_frac = all ones, inexact = 0.
  - Inf: same values as ovf, with inf=1 and ovf=0.
  - NaN: out_int = 0, out_frac = 0, nan=1, other flags 0.
  - Zero: out_int = 0, out_frac = 0, zero=1. out_sign is preserved, so -0 gives sign=1.
  - Denormal: out_int = 0, fraction computed normally; typically inexact=1.
- Boundaries:
  - e = INT_W-1 is the largest non-saturating case.
  - e <= -(FRAC_W+MAN_W+1) gives out_frac = 0 and inexact=1 for any nonzero S.
  - Exactly one of nan/inf/ovf/zero may be set. inexact may accompany only a finite non-ovf result.
  - For the FP32 defaults with e in 0..23, results match the legacy splitter bit-for-bit.

Test Plan:
- Default params; 0x40500000 (3.25) with out_ready=1 -> out_valid exactly 2 cycles later; sign=0, int=0x000003, frac=0x200000, flags=0.
- 0xBF000000 (-0.5) -> sign=1, int=0, frac=0x400000, flags=0. Also 0x80000000 -> sign=1, int=0, frac=0, zero=1.
- 0x501502F9 (~1e10) -> ovf=1, int=0xFFFFFF, frac=0x7FFFFF. 0x7F800000 -> inf=1, same int/frac. 0x7FC00000 -> nan=1, int=0, frac=0.
- 0x30800000 (2^-30) -> int=0, frac=0, inexact=1. 0x3F7FFFFF -> int=0, frac=0x7FFFFF, inexact=1. 0x00000001 (denormal) -> frac=0, inexact=1.
- Stream 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on back-to-back cycles with out_ready=0 for 4 cycles:
  - in_ready falls after 2 accepts.
  - Outputs hold int=1 while stalled.
  - After out_ready=1, the outputs deliver int=1, 2, 3, 4 in order with no loss.
- Assert rst for 1 cycle while two words are in flight -> out_valid=0 and all outputs 0 immediately (asynchronously); in_ready=1 next cycle; the next input completes with normal 2-cycle latency.

Source files
------------

// File: rtl/float_split_pipe_if.sv
// Handshake bus for float_split_pipe: packed float in, split fixed-point fields out.
interface float_split_pipe_if #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned INT_W  = 24,
  parameter int unsigned FRAC_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sign;
  logic [INT_W-1:0]       out_int;
  logic [FRAC_W-1:0]      out_frac;
  logic [4:0]             out_flags;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_int, out_frac, out_flags
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_int, out_frac, out_flags
  );
endinterface

// File: rtl/float_split_pipe.sv
// Two-stage IEEE-754 splitter: S1 decodes class/exponent, S2 shifts the significand
// into integer and truncated fraction fields with saturation and an inexact flag.
module float_split_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned INT_W  = 24,
  parameter int unsigned FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  float_split_pipe_if.slave bus
);
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned E_W   = EXP_W + 1;
  // LSB weight is 2^-(FRAC_W+MAN_W) after the SIG_W guard bits that catch right-shift losses.
  localparam int unsigned BIG_W = SIG_W + MAN_W + FRAC_W + INT_W;
  localparam int          BIAS  = (2 ** (EXP_W - 1)) - 1;

  logic s1_load_c;
  logic s2_load_c;

  // S1 state
  logic                    s1_valid;
  logic                    s1_sign;
  logic                    s1_nan;
  logic                    s1_inf;
  logic                    s1_zero;
  logic [SIG_W-1:0]        s1_sig;
  logic signed [E_W-1:0]   s1_exp;

  // S2 state (drives the outputs)
  logic                    s2_valid;
  logic                    s2_sign;
  logic [INT_W-1:0]        s2_int;
  logic [FRAC_W-1:0]       s2_frac;
  logic [4:0]              s2_flags;

  // Decode fields of the incoming word
  logic [EXP_W-1:0]        exp_field_c;
  logic [MAN_W-1:0]        man_field_c;
  logic                    sign_field_c;
  logic signed [E_W-1:0]   dec_exp_c;
  logic                    exp_zero_c;
  logic                    exp_ones_c;
  logic                    man_nz_c;

  assign sign_field_c = bus.in_data[EXP_W+MAN_W];
  assign exp_field_c  = bus.in_data[MAN_W +: EXP_W];
  assign man_field_c  = bus.in_data[MAN_W-1:0];
  assign exp_zero_c   = (exp_field_c == '0);
  assign exp_ones_c   = &exp_field_c;
  assign man_nz_c     = |man_field_c;
  assign dec_exp_c    = exp_zero_c ? E_W'(1 - BIAS)
                                   : E_W'({1'b0, exp_field_c}) - E_W'(BIAS);

  // Pipeline advance: a stage loads when empty or when the stage after it moves.
  assign s2_load_c    = !s2_valid || bus.out_ready;
  assign s1_load_c    = !s1_valid || s2_load_c;
  assign bus.in_ready = s1_load_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sig   <= '0;
      s1_exp   <= '0;
    end else if (s1_load_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= sign_field_c;
        s1_nan  <= exp_ones_c && man_nz_c;
        s1_inf  <= exp_ones_c && !man_nz_c;
        s1_zero <= exp_zero_c && !man_nz_c;
        s1_sig  <= {!exp_zero_c, man_field_c};
        s1_exp  <= dec_exp_c;
      end
    end
  end

  // S2 shift: significand lands at bit position FRAC_W + e + SIG_W of big_c.
  int                  e_c;
  int                  pos_c;
  logic                ovf_c;
  logic [BIG_W-1:0]    big_c;
  logic                inexact_c;
  logic [INT_W-1:0]    res_int_c;
  logic [FRAC_W-1:0]   res_frac_c;
  logic [4:0]          res_flags_c;

  always_comb begin
    e_c       = int'(s1_exp);
    pos_c     = e_c + int'(FRAC_W) + int'(SIG_W);
    ovf_c     = (e_c >= int'(INT_W));
    big_c     = '0;
    inexact_c = 1'b0;
    if (pos_c >= 0) begin
      big_c     = BIG_W'(s1_sig) << pos_c;
      inexact_c = |big_c[SIG_W+MAN_W-1:0];
    end else begin
      inexact_c = |s1_sig;
    end
  end

  // Class priority picks the special encodings ahead of the shifted result.
  always_comb begin
    res_int_c   = '0;
    res_frac_c  = '0;
    res_flags_c = '0;
    if (s1_nan) begin
      res_flags_c = 5'b10000;
    end else if (s1_inf) begin
      res_int_c   = '1;
      res_frac_c  = '1;
      res_flags_c = 5'b01000;
    end else if (s1_zero) begin
      res_flags_c = 5'b00010;
    end else if (ovf_c) begin
      res_int_c   = '1;
      res_frac_c  = '1;
      res_flags_c = 5'b00100;
    end else begin
      res_int_c   = big_c[SIG_W+MAN_W+FRAC_W +: INT_W];
      res_frac_c  = big_c[SIG_W+MAN_W +: FRAC_W];
      res_flags_c = {4'b0000, inexact_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_int   <= '0;
      s2_frac  <= '0;
      s2_flags <= '0;
    end else if (s2_load_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign  <= s1_sign;
        s2_int   <= res_int_c;
        s2_frac  <= res_frac_c;
        s2_flags <= res_flags_c;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_sign  = s2_sign;
  assign bus.out_int   = s2_int;
  assign bus.out_frac  = s2_frac;
  assign bus.out_flags = s2_flags;
endmodule

// File: tb/tb_float_split_pipe.sv
// Scoreboard bench for float_split_pipe (FP32 defaults): directed vectors, stall and
// reset scenarios, then randomized traffic against an arithmetic reference model.
module tb_float_split_pipe;
  typedef struct packed {
    logic        sign;
    logic [23:0] ival;
    logic [22:0] fval;
    logic [4:0]  flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  float_split_pipe_if bus ();
  float_split_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: |x| scaled by 2^23 as an integer, computed from value, not bit layout.
  function automatic exp_t model(input logic [31:0] d);
    exp_t              r;
    int                ex;
    int                e;
    int                n;
    longint unsigned   s;
    longint unsigned   scaled;
    logic              inx;
    ex = int'(d[30:23]);
    s  = longint'(d[22:0]);
    r  = '0;
    r.sign = d[31];
    if (ex == 255) begin
      if (s != 0) r.flags = 5'b10000;
      else begin r.ival = '1; r.fval = '1; r.flags = 5'b01000; end
    end else if (ex == 0 && s == 0) begin
      r.flags = 5'b00010;
    end else begin
      if (ex != 0) s = s + 64'd8388608;
      e = (ex == 0) ? -126 : ex - 127;
      if (e >= 24) begin
        r.ival = '1; r.fval = '1; r.flags = 5'b00100;
      end else begin
        if (e >= 0) begin
          scaled = s << e;
          inx    = 1'b0;
        end else begin
          n = -e;
          if (n >= 40) begin
            scaled = 0;
            inx    = (s != 0);
          end else begin
            scaled = s >> n;
            inx    = ((s & ((64'd1 << n) - 1)) != 0);
          end
        end
        r.ival  = 24'(scaled >> 23);
        r.fval  = 23'(scaled);
        r.flags = {4'b0000, inx};
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic s, input logic [23:0] i, input logic [22:0] f,
                              input logic [4:0] fl);
    exp_t r;
    r.sign = s; r.ival = i; r.fval = f; r.flags = fl;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every presented result must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    exp_t got;
    if (!rst && bus.out_valid) begin
      got = {bus.out_sign, bus.out_int, bus.out_frac, bus.out_flags};
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out actual=%h required=empty", got);
      end else begin
        check(bus.out_ready ? "out_result" : "out_hold", 64'(got), 64'(sb[0]));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input exp_t ex, input logic ordy,
                      output logic acc);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    acc = v && bus.in_ready;
    if (acc) sb.push_back(ex);
  endtask

  task automatic send(input logic [31:0] d, input exp_t ex);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) step(1'b1, d, ex, 1'b1, acc);
    if (!acc) check("send_timeout", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 50 && (sb.size() != 0 || bus.out_valid); k++)
      step(1'b0, 32'h0, '0, 1'b1, acc);
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic latency_test(input logic [31:0] d, input exp_t ex);
    logic acc;
    step(1'b1, d, ex, 1'b1, acc);
    check("lat_accept", 64'(acc), 64'(1));
    step(1'b0, 32'h0, '0, 1'b1, acc);
    check("lat_cycle1_valid", 64'(bus.out_valid), 64'(0));
    step(1'b0, 32'h0, '0, 1'b1, acc);
    check("lat_cycle2_valid", 64'(bus.out_valid), 64'(1));
    drain();
  endtask

  logic [31:0] dir_d[14];
  exp_t        dir_e[14];
  logic [31:0] str_d[4];

  initial begin
    logic        acc;
    logic        pend;
    logic [31:0] rd;
    int          idx;

    dir_d[0]  = 32'hBF000000; dir_e[0]  = mk(1'b1, 24'h0,      23'h400000, 5'b00000);
    dir_d[1]  = 32'h80000000; dir_e[1]  = mk(1'b1, 24'h0,      23'h0,      5'b00010);
    dir_d[2]  = 32'h501502F9; dir_e[2]  = mk(1'b0, 24'hFFFFFF, 23'h7FFFFF, 5'b00100);
    dir_d[3]  = 32'h7F800000; dir_e[3]  = mk(1'b0, 24'hFFFFFF, 23'h7FFFFF, 5'b01000);
    dir_d[4]  = 32'h7FC00000; dir_e[4]  = mk(1'b0, 24'h0,      23'h0,      5'b10000);
    dir_d[5]  = 32'h30800000; dir_e[5]  = mk(1'b0, 24'h0,      23'h0,      5'b00001);
    dir_d[6]  = 32'h3F7FFFFF; dir_e[6]  = mk(1'b0, 24'h0,      23'h7FFFFF, 5'b00001);
    dir_d[7]  = 32'h00000001; dir_e[7]  = mk(1'b0, 24'h0,      23'h0,      5'b00001);
    dir_d[8]  = 32'h4B7FFFFF; dir_e[8]  = mk(1'b0, 24'hFFFFFF, 23'h0,      5'b00000);
    dir_d[9]  = 32'h4B800000; dir_e[9]  = mk(1'b0, 24'hFFFFFF, 23'h7FFFFF, 5'b00100);
    dir_d[10] = 32'h28000000; dir_e[10] = mk(1'b0, 24'h0,      23'h0,      5'b00001);
    dir_d[11] = 32'h34000000; dir_e[11] = mk(1'b0, 24'h0,      23'h000001, 5'b00000);
    dir_d[12] = 32'hFFC00001; dir_e[12] = mk(1'b1, 24'h0,      23'h0,      5'b10000);
    dir_d[13] = 32'hC1230000; dir_e[13] = mk(1'b1, 24'h00000A, 23'h180000, 5'b00000);
    str_d[0] = 32'h3F800000; str_d[1] = 32'h40000000;
    str_d[2] = 32'h40400000; str_d[3] = 32'h40800000;

    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_out_word", 64'({bus.out_sign, bus.out_int, bus.out_frac, bus.out_flags}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));

    latency_test(32'h40500000, mk(1'b0, 24'h3, 23'h200000, 5'b00000));

    for (int i = 0; i < 14; i++) begin
      send(dir_d[i], dir_e[i]);
      if (i % 3 == 0) step(1'b0, 32'h0, '0, 1'b1, acc);
    end
    drain();

    // Back-to-back stream with downstream stalled for four cycles.
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b1, str_d[idx], mk(1'b0, 24'(idx + 1), 23'h0, 5'b00000), 1'b0, acc);
      if (acc) idx++;
    end
    check("stall_accepts", 64'(idx), 64'(2));
    check("stall_in_ready", 64'(bus.in_ready), 64'(0));
    check("stall_hold_int", 64'(bus.out_int), 64'(1));
    for (int k = 0; k < 20 && idx < 4; k++) begin
      step(1'b1, str_d[idx], mk(1'b0, 24'(idx + 1), 23'h0, 5'b00000), 1'b1, acc);
      if (acc) idx++;
    end
    check("stream_all_accepted", 64'(idx), 64'(4));
    drain();

    // Reset with two words in flight.
    step(1'b1, 32'h40A00000, model(32'h40A00000), 1'b0, acc);
    step(1'b1, 32'h40C00000, model(32'h40C00000), 1'b0, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_out_word", 64'({bus.out_sign, bus.out_int, bus.out_frac, bus.out_flags}), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", 64'(bus.in_ready), 64'(1));
    latency_test(32'h41200000, mk(1'b0, 24'hA, 23'h0, 5'b00000));

    // Randomized traffic with random backpressure.
    pend = 1'b0;
    rd   = 32'h0;
    for (int c = 0; c < 800; c++) begin
      if (!pend && $urandom_range(0, 99) < 70) begin
        pend = 1'b1;
        if ($urandom_range(0, 1) == 0) rd = $urandom;
        else rd = {1'($urandom), 8'($urandom_range(95, 160)), 23'($urandom)};
      end
      step(pend, rd, model(rd), 1'($urandom_range(0, 99) < 75), acc);
      if (acc) pend = 1'b0;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
